// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM controller.
// DPRAM_PARITY_EN adds one even-parity bit to every stored word.
package dpram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned RD_OLD = 0;
    localparam int unsigned RD_NEW = 1;

`ifdef DPRAM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

endpackage

// File: rtl/dpram_rd_port.sv
// Per-port registered read output with rvalid pulse and optional parity check.
// DPRAM_PARITY_EN enables perr_o.
module dpram_rd_port #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STORE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en_i,
    input  logic [STORE_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0]  q_o,
`ifdef DPRAM_PARITY_EN
    output logic                   perr_o,
`endif
    output logic                   rvalid_o
);

    logic [DATA_WIDTH-1:0] q_q;
    logic                  rvalid_q;

    // q only moves on an accepted read; otherwise it holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en_i;
            if (rd_en_i) begin
                q_q <= word_i[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic perr_q;

    // stored word includes its parity bit, so any odd reduction is an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= rd_en_i & (^word_i);
        end
    end

    assign perr_o = perr_q;
`endif

    assign q_o      = q_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Dual-port RAM with power-on clear, collision arbitration and read-during-write policy.
// DPRAM_PARITY_EN adds a parity bit per word and perr_a/perr_b outputs.
module dual_port_ram_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RD_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_a,
    input  logic                  cs_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
`ifdef DPRAM_PARITY_EN
    output logic                  perr_a,
    output logic                  perr_b,
`endif
    output logic                  ready,
    output logic                  collision
);

    localparam int unsigned SW = DATA_WIDTH + PAR_W;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  ready_q;
    logic                  collision_q;
    logic [SW-1:0]         mem_q [DEPTH];

    logic          acc_a, acc_b, in_range_a, in_range_b, same_addr;
    logic          wr_a, wr_b, rd_a, rd_b;
    logic [SW-1:0] wword_a, wword_b, rword_a, rword_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ready_q     <= (state_d == RUN);
            collision_q <= acc_a & we_a & acc_b & we_b & same_addr;
        end
    end

    // INIT walks 0..DEPTH-1 clearing one word per cycle, then RUN forever
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign acc_a      = cs_a & ready_q;
    assign acc_b      = cs_b & ready_q;
    assign in_range_a = (32'(addr_a) < DEPTH);
    assign in_range_b = (32'(addr_b) < DEPTH);
    assign same_addr  = (addr_a == addr_b);

    // port A wins a same-address dual write
    assign wr_a = acc_a & we_a & in_range_a;
    assign wr_b = acc_b & we_b & in_range_b & ~(wr_a & same_addr);
    assign rd_a = acc_a & ~we_a;
    assign rd_b = acc_b & ~we_b;

`ifdef DPRAM_PARITY_EN
    assign wword_a = {^data_a, data_a};
    assign wword_b = {^data_b, data_b};
`else
    assign wword_a = data_a;
    assign wword_b = data_b;
`endif

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[IW'(init_cnt_q)] <= '0;
        end else begin
            if (wr_a) begin
                mem_q[IW'(addr_a)] <= wword_a;
            end
            if (wr_b) begin
                mem_q[IW'(addr_b)] <= wword_b;
            end
        end
    end

    // out-of-range reads return zero; RD_NEW forwards the other port's write
    always_comb begin
        rword_a = '0;
        rword_b = '0;
        if (in_range_a) begin
            if (RD_MODE == RD_NEW && wr_b && same_addr) begin
                rword_a = wword_b;
            end else begin
                rword_a = mem_q[IW'(addr_a)];
            end
        end
        if (in_range_b) begin
            if (RD_MODE == RD_NEW && wr_a && same_addr) begin
                rword_b = wword_a;
            end else begin
                rword_b = mem_q[IW'(addr_b)];
            end
        end
    end

    dpram_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .STORE_WIDTH(SW)
    ) u_rd_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (rd_a),
        .word_i  (rword_a),
        .q_o     (q_a),
`ifdef DPRAM_PARITY_EN
        .perr_o  (perr_a),
`endif
        .rvalid_o(rvalid_a)
    );

    dpram_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .STORE_WIDTH(SW)
    ) u_rd_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (rd_b),
        .word_i  (rword_b),
        .q_o     (q_b),
`ifdef DPRAM_PARITY_EN
        .perr_o  (perr_b),
`endif
        .rvalid_o(rvalid_b)
    );

    assign ready     = ready_q;
    assign collision = collision_q;

endmodule
